rf_wb_arbiter: RTL

//  Controls the single register-file write port of the RV32I core. Inputs are

---
 rtl/rf_wb_arbiter_if.sv | 40 ++++
 rtl/rf_wb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_if
// Bundle of every signal between the RV32I core (pipeline writeback, LSU
// response path, H.264 accelerator result port) and the register-file
// write-port arbiter.
//   master : core side, drives the wb_*, lsu_* and acc_* request signals
//   slave  : arbiter side, drives acc_gnt_o, stall_o, rf_* and ld_timeout_o
// ---------------------------------------------------------------------------
interface rf_wb_arbiter_if;
  logic        wb_valid_i;
  logic [1:0]  wb_sel_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] alu_result_i;
  logic [31:0] pc4_i;
  logic        lsu_rsp_valid_i;
  logic [31:0] lsu_rsp_data_i;
  logic        acc_req_i;
  logic [4:0]  acc_rd_i;
  logic [31:0] acc_data_i;
  logic        acc_gnt_o;
  logic        stall_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        ld_timeout_o;

  modport master (
    output wb_valid_i, wb_sel_i, wb_rd_i, alu_result_i, pc4_i,
    output lsu_rsp_valid_i, lsu_rsp_data_i,
    output acc_req_i, acc_rd_i, acc_data_i,
    input  acc_gnt_o, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, ld_timeout_o
  );

  modport slave (
    input  wb_valid_i, wb_sel_i, wb_rd_i, alu_result_i, pc4_i,
    input  lsu_rsp_valid_i, lsu_rsp_data_i,
    input  acc_req_i, acc_rd_i, acc_data_i,
    output acc_gnt_o, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, ld_timeout_o
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Owns the single RF write port. Chooses between the pipeline writeback
// (ALU result / PC+4), late load responses and the accelerator, stalls the
// pipeline while a load is outstanding or the accelerator is being forced in,
// and registers the resulting write strobe/address/data.
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : rf_wb_arbiter_if.slave (writeback, LSU, accelerator, RF write)
// Parameters:
//   STARVE_MAX : ungranted accelerator cycles before a forced grant (>=1)
//   LD_TIMEOUT : WAIT_LD cycles without a response before abort (>=1)
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned LD_TIMEOUT = 255
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rf_wb_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_LD   = 2'd1;
  localparam logic [1:0] S_ACC_FORCE = 2'd2;

  localparam int unsigned TW = $clog2(LD_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(LD_TIMEOUT);
  localparam logic [SW-1:0] STV_LIMIT = SW'(STARVE_MAX);

  logic [1:0]    r_state, w_state_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;
  logic [4:0]    r_ld_rd, w_ld_rd_nxt;

  logic        w_pipe_wr, w_wb_load, w_force_go;
  logic        w_gnt, w_stall, w_tmo_hit;
  logic        w_wr_en, w_we_eff;
  logic [4:0]  w_wr_rd;
  logic [31:0] w_wr_data;

  logic        r_we, r_tmo_pulse;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;

  assign w_pipe_wr = bus.wb_valid_i & ((bus.wb_sel_i == 2'b01) | (bus.wb_sel_i == 2'b10));
  assign w_wb_load = bus.wb_valid_i & (bus.wb_sel_i == 2'b00);
  // IDLE only: this ungranted cycle would bring the starve count to its limit.
  assign w_force_go = bus.acc_req_i & ~w_gnt & ((r_starve + SW'(1)) == STV_LIMIT);

  // Next-state, grant/stall and write-port selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_tmo_nxt    = r_tmo;
    w_starve_nxt = r_starve;
    w_ld_rd_nxt  = r_ld_rd;
    w_gnt        = 1'b0;
    w_stall      = 1'b0;
    w_tmo_hit    = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_rd      = 5'd0;
    w_wr_data    = 32'd0;
    case (r_state)
      S_IDLE: begin
        w_gnt = bus.acc_req_i & ~w_pipe_wr & ~w_wb_load;
        if (w_wb_load & bus.lsu_rsp_valid_i) begin
          w_wr_en   = 1'b1;
          w_wr_rd   = bus.wb_rd_i;
          w_wr_data = bus.lsu_rsp_data_i;
        end else if (w_wb_load) begin
          w_stall     = 1'b1;
          w_ld_rd_nxt = bus.wb_rd_i;
          w_tmo_nxt   = {TW{1'b0}};
        end else if (w_pipe_wr) begin
          w_wr_en   = 1'b1;
          w_wr_rd   = bus.wb_rd_i;
          w_wr_data = (bus.wb_sel_i == 2'b01) ? bus.alu_result_i : bus.pc4_i;
        end else if (w_gnt) begin
          w_wr_en   = 1'b1;
          w_wr_rd   = bus.acc_rd_i;
          w_wr_data = bus.acc_data_i;
        end else begin
          w_wr_en = 1'b0;
        end
        if (bus.acc_req_i & ~w_gnt) begin
          w_starve_nxt = r_starve + SW'(1);
        end else begin
          w_starve_nxt = {SW{1'b0}};
        end
        // A forced cycle wins over recording a new load; the held load is
        // re-presented once the forced cycle is over.
        if (w_force_go) begin
          w_state_nxt = S_ACC_FORCE;
        end else if (w_wb_load & ~bus.lsu_rsp_valid_i) begin
          w_state_nxt = S_WAIT_LD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_LD: begin
        // Starve count is frozen here: no grant is possible while waiting.
        if (bus.lsu_rsp_valid_i) begin
          w_wr_en     = 1'b1;
          w_wr_rd     = r_ld_rd;
          w_wr_data   = bus.lsu_rsp_data_i;
          w_state_nxt = S_IDLE;
        end else if (r_tmo == TMO_LIMIT) begin
          w_wr_en     = 1'b1;
          w_wr_rd     = r_ld_rd;
          w_wr_data   = 32'd0;
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall   = 1'b1;
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_ACC_FORCE: begin
        w_stall = 1'b1;
        w_gnt   = bus.acc_req_i;
        if (w_gnt) begin
          w_wr_en   = 1'b1;
          w_wr_rd   = bus.acc_rd_i;
          w_wr_data = bus.acc_data_i;
        end else begin
          w_wr_en = 1'b0;
        end
        w_starve_nxt = {SW{1'b0}};
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_starve_nxt = {SW{1'b0}};
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  // x0 is hard-wired zero: the decision proceeds but the strobe is dropped.
  assign w_we_eff = w_wr_en & (w_wr_rd != 5'd0);

  // State, counters and registered RF write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_tmo       <= {TW{1'b0}};
      r_starve    <= {SW{1'b0}};
      r_ld_rd     <= 5'd0;
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_wdata     <= 32'd0;
      r_tmo_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmo       <= w_tmo_nxt;
      r_starve    <= w_starve_nxt;
      r_ld_rd     <= w_ld_rd_nxt;
      r_we        <= w_we_eff;
      r_waddr     <= w_we_eff ? w_wr_rd : 5'd0;
      r_wdata     <= w_we_eff ? w_wr_data : 32'd0;
      r_tmo_pulse <= w_tmo_hit;
    end
  end

  assign bus.acc_gnt_o    = w_gnt;
  assign bus.stall_o      = w_stall;
  assign bus.rf_we_o      = r_we;
  assign bus.rf_waddr_o   = r_waddr;
  assign bus.rf_wdata_o   = r_wdata;
  assign bus.ld_timeout_o = r_tmo_pulse;
endmodule
